// File: rtl/gf2_pkg.sv
// Shared encodings for the GF(2) shift-register column: row select codes,
// command opcodes and the sequencer state type.
package gf2_pkg;

    localparam logic [1:0] SEL_NOP = 2'b00;
    localparam logic [1:0] SEL_SHL = 2'b01;
    localparam logic [1:0] SEL_SHR = 2'b10;
    localparam logic [1:0] SEL_SHD = 2'b11;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_ROTL   = 2'b01;
    localparam logic [1:0] OP_ROTR   = 2'b10;
    localparam logic [1:0] OP_UNLOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ROT    = 2'd2,
        ST_UNLOAD = 2'd3
    } state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gf2_step_cnt.sv
// Loadable down-counter that tracks remaining steps of the current command;
// reports zero and last-step flags.
module gf2_step_cnt #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o,
    output logic         last_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign zero_o = (cnt_q == '0);
    assign last_o = (cnt_q == W'(1));

    // Decrement saturates at zero so a stray enable cannot wrap the count.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && !zero_o)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/gf2_sr_seq.sv
// Command sequencer for a column of M cascaded N-bit GF(2) shift-register rows:
// loads, rotates and unloads the column via a broadcast select.
module gf2_sr_seq
    import gf2_pkg::*;
#(
    parameter int N  = 32,
    parameter int M  = 32,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_amt,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic [1:0]    arr_sel,
    output logic [N-1:0]  arr_din,
    input  logic [N-1:0]  arr_dout,
    output logic          busy,
    output logic          done
);

    localparam int CW = max2(AW, $clog2(M + 1));

    state_e        state_q;
    logic          dir_q;
    logic          done_q;

    logic          accept;
    logic          is_rot;
    logic          amt_zero;
    logic          advance;
    logic          cnt_load;
    logic [CW-1:0] cnt_load_val;
    logic          cnt_zero;
    logic          cnt_last;

    assign accept       = cmd_valid && (state_q == ST_IDLE);
    assign is_rot       = (cmd_op == OP_ROTL) || (cmd_op == OP_ROTR);
    assign amt_zero     = (cmd_amt == '0);
    assign cnt_load     = accept && !(is_rot && amt_zero);
    assign cnt_load_val = is_rot ? CW'(cmd_amt) : CW'(M);

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign in_ready  = (state_q == ST_LOAD);
    assign out_valid = (state_q == ST_UNLOAD);
    assign out_data  = arr_dout;
    assign done      = done_q;

    // One array step per accepted word (LOAD/UNLOAD) or per cycle (ROT).
    always_comb begin
        advance = 1'b0;
        arr_sel = SEL_NOP;
        arr_din = '0;
        case (state_q)
            ST_LOAD: begin
                advance = in_valid;
                if (in_valid) begin
                    arr_sel = SEL_SHD;
                    arr_din = in_data;
                end
            end
            ST_ROT: begin
                advance = 1'b1;
                arr_sel = dir_q ? SEL_SHR : SEL_SHL;
            end
            ST_UNLOAD: begin
                advance = out_ready;
                if (out_ready)
                    arr_sel = SEL_SHD;
            end
            default: ;
        endcase
    end

    gf2_step_cnt #(.W(CW)) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (advance),
        .zero_o     (cnt_zero),
        .last_o     (cnt_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        case (cmd_op)
                            OP_LOAD:   state_q <= ST_LOAD;
                            OP_UNLOAD: state_q <= ST_UNLOAD;
                            default: begin
                                dir_q <= (cmd_op == OP_ROTR);
                                // A zero-length rotate completes without touching the array.
                                if (amt_zero)
                                    done_q <= 1'b1;
                                else
                                    state_q <= ST_ROT;
                            end
                        endcase
                    end
                end
                default: begin
                    if (advance && cnt_last) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end else if (cnt_zero) begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf2_sr_seq.sv
// Directed bench for gf2_sr_seq with a behavioural 4x8 row column attached.
module tb_gf2_sr_seq;
    import gf2_pkg::*;

    localparam int N  = 8;
    localparam int M  = 4;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_amt;
    logic          in_valid, in_ready;
    logic [N-1:0]  in_data;
    logic          out_valid, out_ready;
    logic [N-1:0]  out_data;
    logic [1:0]    arr_sel;
    logic [N-1:0]  arr_din, arr_dout;
    logic          busy, done;

    logic [N-1:0]  rows [M];
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    gf2_sr_seq #(.N(N), .M(M), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_amt(cmd_amt),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .arr_sel(arr_sel), .arr_din(arr_din), .arr_dout(arr_dout),
        .busy(busy), .done(done)
    );

    // Reference column: row0 fed from arr_din, bottom row drives arr_dout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < M; r++) rows[r] <= '0;
        end else begin
            case (arr_sel)
                SEL_SHL: for (int r = 0; r < M; r++) rows[r] <= {rows[r][N-2:0], rows[r][N-1]};
                SEL_SHR: for (int r = 0; r < M; r++) rows[r] <= {rows[r][0], rows[r][N-1:1]};
                SEL_SHD: begin
                    rows[0] <= arr_din;
                    for (int r = 1; r < M; r++) rows[r] <= rows[r-1];
                end
                default: ;
            endcase
        end
    end
    assign arr_dout = rows[M-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [AW-1:0] amt);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_amt   = amt;
        #1;
        chk("accept_ready", 32'(cmd_ready), 32'h1);
        chk("accept_sel", 32'(arr_sel), 32'(SEL_NOP));
    endtask

    task automatic check_done(input string tag);
        @(negedge clk);
        cmd_valid = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk({tag, "_done"}, 32'(done), 32'h1);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h1);
        chk({tag, "_sel_idle"}, 32'(arr_sel), 32'(SEL_NOP));
        $display("txn %s complete rows0=%02h rows3=%02h", tag, rows[0], rows[M-1]);
    endtask

    logic [6:0] pat;
    logic [N-1:0] word;
    int w;

    initial begin
        reset = 1'b1; cmd_valid = 0; cmd_op = OP_LOAD; cmd_amt = '0;
        in_valid = 0; in_data = '0; out_ready = 0;
        #2;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_sel", 32'(arr_sel), 32'h0);
        chk("rst_din", 32'(arr_din), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // LOAD 01,02,04,08 gap-free, then UNLOAD in FIFO order
        issue(OP_LOAD, '0);
        for (int i = 0; i < M; i++) begin
            @(negedge clk);
            cmd_valid = 0; in_valid = 1; in_data = 8'(1 << i);
            #1;
            chk("load_sel", 32'(arr_sel), 32'(SEL_SHD));
            chk("load_din", 32'(arr_din), 32'(8'(1 << i)));
            chk("load_busy", 32'(busy & in_ready & ~cmd_ready), 32'h1);
        end
        check_done("load1");
        chk("load1_bottom", 32'(rows[M-1]), 32'h01);
        chk("load1_top", 32'(rows[0]), 32'h08);
        @(negedge clk); #1;
        chk("load1_done_low", 32'(done), 32'h0);
        issue(OP_UNLOAD, '0);
        for (int i = 0; i < M; i++) begin
            @(negedge clk);
            cmd_valid = 0; out_ready = 1;
            #1;
            chk("unl_valid", 32'(out_valid), 32'h1);
            chk("unl_data", 32'(out_data), 32'(8'(1 << i)));
            chk("unl_sel", 32'(arr_sel), 32'(SEL_SHD));
            chk("unl_din", 32'(arr_din), 32'h0);
            $display("txn unload word %0d = %02h", i, out_data);
        end
        check_done("unload1");
        chk("unload1_zero", 32'(rows[M-1]), 32'h0);

        // Fill with 0x81, ROTL 3 -> 0x0C, ROTR 3 -> 0x81
        issue(OP_LOAD, '0);
        for (int i = 0; i < M; i++) begin
            @(negedge clk);
            cmd_valid = 0; in_valid = 1; in_data = 8'h81;
            #1;
            chk("fill_sel", 32'(arr_sel), 32'(SEL_SHD));
        end
        check_done("fill81");
        issue(OP_ROTL, 3'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmd_valid = 0;
            #1;
            chk("rotl_sel", 32'(arr_sel), 32'(SEL_SHL));
            chk("rotl_done_low", 32'(done), 32'h0);
        end
        check_done("rotl3");
        chk("rotl_row0", 32'(rows[0]), 32'h0C);
        chk("rotl_row3", 32'(rows[M-1]), 32'h0C);
        issue(OP_ROTR, 3'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmd_valid = 0;
            #1;
            chk("rotr_sel", 32'(arr_sel), 32'(SEL_SHR));
        end
        check_done("rotr3");
        chk("rotr_row1", 32'(rows[1]), 32'h81);

        // Zero-amount rotate: done next cycle, no busy, no array activity
        issue(OP_ROTL, 3'd0);
        check_done("rotl0");
        chk("rotl0_busy", 32'(busy), 32'h0);
        @(negedge clk); #1;
        chk("rotl0_done_low", 32'(done), 32'h0);
        chk("rotl0_rows", 32'(rows[2]), 32'h81);

        issue(OP_UNLOAD, '0);
        for (int i = 0; i < M; i++) begin
            @(negedge clk);
            cmd_valid = 0; out_ready = 1;
            #1;
            chk("drain_data", 32'(out_data), 32'h81);
        end
        check_done("drain81");

        // Gappy LOAD with a second command held pending; accepted in the done cycle
        issue(OP_LOAD, '0);
        pat = 7'b1011001;
        w = 0;
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            cmd_valid = 1; cmd_op = OP_UNLOAD;
            in_valid = pat[j];
            word = 8'(1 << w);
            in_data = pat[j] ? word : 8'hFF;
            #1;
            chk("gap_sel", 32'(arr_sel), pat[j] ? 32'(SEL_SHD) : 32'(SEL_NOP));
            chk("gap_cmd_ready", 32'(cmd_ready), 32'h0);
            if (pat[j]) begin
                chk("gap_din", 32'(arr_din), 32'(word));
                w++;
            end
        end
        @(negedge clk);
        in_valid = 0;
        #1;
        chk("gap_done", 32'(done), 32'h1);
        chk("gap_done_ready", 32'(cmd_ready), 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmd_valid = 0; out_ready = 0;
            #1;
            chk("stall_busy", 32'(busy & out_valid), 32'h1);
            chk("stall_data", 32'(out_data), 32'h01);
            chk("stall_sel", 32'(arr_sel), 32'(SEL_NOP));
        end
        for (int i = 0; i < M; i++) begin
            @(negedge clk);
            out_ready = 1;
            #1;
            chk("gap_unl_data", 32'(out_data), 32'(8'(1 << i)));
            chk("gap_unl_sel", 32'(arr_sel), 32'(SEL_SHD));
        end
        check_done("gap_unload");

        // Reset mid-rotate: immediate idle, no done, new command accepted at once
        issue(OP_ROTL, 3'd7);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            cmd_valid = 0;
            #1;
            chk("rot7_sel", 32'(arr_sel), 32'(SEL_SHL));
        end
        @(negedge clk);
        reset = 1;
        #1;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_sel", 32'(arr_sel), 32'(SEL_NOP));
        chk("abort_ready", 32'(cmd_ready), 32'h1);
        chk("abort_done", 32'(done), 32'h0);
        @(negedge clk);
        reset = 0;
        #1;
        chk("abort_done_after", 32'(done), 32'h0);
        issue(OP_UNLOAD, '0);
        for (int i = 0; i < M; i++) begin
            @(negedge clk);
            cmd_valid = 0; out_ready = 1;
            #1;
            chk("post_rst_valid", 32'(out_valid), 32'h1);
            chk("post_rst_data", 32'(out_data), 32'h0);
        end
        check_done("post_reset_unload");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
